// File: rtl/if_id_fifo.sv
// IF/ID decoupling buffer: DEPTH-entry instruction queue feeding a registered output stage.
// Optional feature: define IF_ID_FIFO_PARITY_EN to store and recheck even parity per entry.

`ifndef IF_ID_flush
`define IF_ID_flush 2'b01
`endif
`ifndef IF_ID_hold
`define IF_ID_hold 2'b10
`endif

module if_id_fifo #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic                       i_Clk,
  input  logic                       i_reset,
  input  logic                       i_wr_valid,
  output logic                       o_wr_ready,
  input  logic [ADDR_W-1:0]          i_pc_addr,
  input  logic [DATA_W-1:0]          i_inst_data,
  input  logic [1:0]                 i_hold_flag,
  output logic                       o_valid,
  output logic [ADDR_W-1:0]          o_pc_addr,
  output logic [DATA_W-1:0]          o_inst_data,
`ifdef IF_ID_FIFO_PARITY_EN
  output logic                       o_parity_err,
`endif
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [DATA_W-1:0] mem_inst [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic flush;
  logic hold;
  logic run;
  logic empty;
  logic push;
  logic pop;
  logic bypass;
  logic enq;

  assign flush = (i_hold_flag == `IF_ID_flush);
  assign hold  = (i_hold_flag == `IF_ID_hold) && !flush;
  assign run   = !flush && !hold;
  assign empty = (count == '0);

  // Ready depends only on occupancy, so a full queue never accepts even when popping.
  assign o_wr_ready = (count != CNT_W'(DEPTH));
  assign push       = i_wr_valid && o_wr_ready;
  assign pop        = run && !empty;
  assign bypass     = run && empty && push;
  assign enq        = push && !flush && !bypass;
  assign o_count    = count;

  always_ff @(posedge i_Clk) begin
    if (enq) begin
      mem_pc[wr_ptr]   <= i_pc_addr;
      mem_inst[wr_ptr] <= i_inst_data;
    end
  end

  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (enq && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !enq)
        count <= count - CNT_W'(1);
    end
  end

  // Output stage: flush and empty-queue bubbles both present a NOP with valid low.
  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid     <= 1'b0;
      o_pc_addr   <= '0;
      o_inst_data <= '0;
    end else if (flush) begin
      o_valid     <= 1'b0;
      o_pc_addr   <= '0;
      o_inst_data <= NOP_INST;
    end else if (run) begin
      if (!empty) begin
        o_valid     <= 1'b1;
        o_pc_addr   <= mem_pc[rd_ptr];
        o_inst_data <= mem_inst[rd_ptr];
      end else if (push) begin
        o_valid     <= 1'b1;
        o_pc_addr   <= i_pc_addr;
        o_inst_data <= i_inst_data;
      end else begin
        o_valid     <= 1'b0;
        o_pc_addr   <= '0;
        o_inst_data <= NOP_INST;
      end
    end
  end

`ifdef IF_ID_FIFO_PARITY_EN
  logic mem_par [DEPTH];
  logic head_bad;

  assign head_bad = ((^{mem_pc[rd_ptr], mem_inst[rd_ptr]}) != mem_par[rd_ptr]);

  always_ff @(posedge i_Clk) begin
    if (enq) mem_par[wr_ptr] <= ^{i_pc_addr, i_inst_data};
  end

  // Sticky until reset or flush; bypassed pairs never touch storage so are not checked.
  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset)
      o_parity_err <= 1'b0;
    else if (flush)
      o_parity_err <= 1'b0;
    else if (pop && head_bad)
      o_parity_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_if_id_fifo.sv
// Self-checking bench for if_id_fifo: table-driven cycle vectors plus hand-written
// sequences for wrap-around, mid-stream reset and (with IF_ID_FIFO_PARITY_EN) parity.

`ifndef IF_ID_flush
`define IF_ID_flush 2'b01
`endif
`ifndef IF_ID_hold
`define IF_ID_hold 2'b10
`endif

module tb_if_id_fifo;

  localparam logic [1:0]  RUN = 2'b00;
  localparam logic [1:0]  FL  = `IF_ID_flush;
  localparam logic [1:0]  HO  = `IF_ID_hold;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        i_Clk;
  logic        i_reset;
  logic        i_wr_valid;
  logic        o_wr_ready;
  logic [31:0] i_pc_addr;
  logic [31:0] i_inst_data;
  logic [1:0]  i_hold_flag;
  logic        o_valid;
  logic [31:0] o_pc_addr;
  logic [31:0] o_inst_data;
  logic [2:0]  o_count;
`ifdef IF_ID_FIFO_PARITY_EN
  logic        o_parity_err;
`endif

  int compared;
  int mismatched;

  if_id_fifo #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .NOP_INST(NOP)) dut (
    .i_Clk       (i_Clk),
    .i_reset     (i_reset),
    .i_wr_valid  (i_wr_valid),
    .o_wr_ready  (o_wr_ready),
    .i_pc_addr   (i_pc_addr),
    .i_inst_data (i_inst_data),
    .i_hold_flag (i_hold_flag),
    .o_valid     (o_valid),
    .o_pc_addr   (o_pc_addr),
    .o_inst_data (o_inst_data),
`ifdef IF_ID_FIFO_PARITY_EN
    .o_parity_err(o_parity_err),
`endif
    .o_count     (o_count)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic        wr_valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  hold;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [2:0]  exp_count;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] instOf(input logic [31:0] pc);
    return 32'h1000_0000 | pc;
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                              input logic [1:0] hf, input logic ev, input logic [31:0] epc,
                              input logic [31:0] einst, input logic [2:0] ecnt, input logic erdy);
    vec_t r;
    r.wr_valid = v;   r.pc = pc;       r.inst = inst;         r.hold = hf;
    r.exp_valid = ev; r.exp_pc = epc;  r.exp_inst = einst;    r.exp_count = ecnt;
    r.exp_ready = erdy;
    return r;
  endfunction

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                               input logic [1:0] hf);
    i_wr_valid  = v;
    i_pc_addr   = pc;
    i_inst_data = inst;
    i_hold_flag = hf;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic ev, input logic [31:0] epc,
                          input logic [31:0] einst, input logic [2:0] ecnt, input logic erdy);
    checkOutput({tag, ".valid"}, {31'd0, o_valid}, {31'd0, ev});
    checkOutput({tag, ".pc"},    o_pc_addr, epc);
    checkOutput({tag, ".inst"},  o_inst_data, einst);
    checkOutput({tag, ".count"}, {29'd0, o_count}, {29'd0, ecnt});
    checkOutput({tag, ".ready"}, {31'd0, o_wr_ready}, {31'd0, erdy});
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    vecs.push_back(mk(1, 32'h0,  32'h00500093, RUN, 1, 32'h0,  32'h00500093, 0, 1));
    vecs.push_back(mk(0, 32'h0,  32'h0,        RUN, 0, 32'h0,  NOP,          0, 1));
    vecs.push_back(mk(1, 32'h0,  32'h0A0A0A0A, RUN, 1, 32'h0,  32'h0A0A0A0A, 0, 1));
    vecs.push_back(mk(1, 32'h4,  instOf(4),    HO,  1, 32'h0,  32'h0A0A0A0A, 1, 1));
    vecs.push_back(mk(1, 32'h8,  instOf(8),    HO,  1, 32'h0,  32'h0A0A0A0A, 2, 1));
    vecs.push_back(mk(1, 32'hC,  instOf(12),   HO,  1, 32'h0,  32'h0A0A0A0A, 3, 1));
    vecs.push_back(mk(1, 32'h10, instOf(16),   HO,  1, 32'h0,  32'h0A0A0A0A, 4, 0));
    vecs.push_back(mk(1, 32'h14, instOf(20),   HO,  1, 32'h0,  32'h0A0A0A0A, 4, 0));
    vecs.push_back(mk(1, 32'h18, instOf(24),   HO,  1, 32'h0,  32'h0A0A0A0A, 4, 0));
    vecs.push_back(mk(1, 32'h99, instOf(32'h99), RUN, 1, 32'h4, instOf(4),   3, 1));
    vecs.push_back(mk(0, 32'h0,  32'h0,        RUN, 1, 32'h8,  instOf(8),    2, 1));
    vecs.push_back(mk(0, 32'h0,  32'h0,        RUN, 1, 32'hC,  instOf(12),   1, 1));
    vecs.push_back(mk(0, 32'h0,  32'h0,        RUN, 1, 32'h10, instOf(16),   0, 1));
    vecs.push_back(mk(1, 32'h30, instOf(48),   RUN, 1, 32'h30, instOf(48),   0, 1));
    vecs.push_back(mk(1, 32'h20, instOf(32),   HO,  1, 32'h30, instOf(48),   1, 1));
    vecs.push_back(mk(1, 32'h24, instOf(36),   HO,  1, 32'h30, instOf(48),   2, 1));
    vecs.push_back(mk(1, 32'h28, instOf(40),   HO,  1, 32'h30, instOf(48),   3, 1));
    vecs.push_back(mk(1, 32'h2C, instOf(44),   FL,  0, 32'h0,  NOP,          0, 1));
    vecs.push_back(mk(0, 32'h0,  32'h0,        RUN, 0, 32'h0,  NOP,          0, 1));

    i_reset     = 1'b1;
    i_wr_valid  = 1'b0;
    i_pc_addr   = '0;
    i_inst_data = '0;
    i_hold_flag = RUN;
    repeat (2) @(posedge i_Clk);
    #1;
    i_reset = 1'b0;
    #1;
    checkAll("reset", 0, 32'h0, 32'h0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].wr_valid, vecs[i].pc, vecs[i].inst, vecs[i].hold);
      checkAll($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_inst,
               vecs[i].exp_count, vecs[i].exp_ready);
    end

    // Wrap: prime two entries under hold, then push and pop together for 10 cycles.
    applyStimulus(1, 32'h0, instOf(0), HO);
    applyStimulus(1, 32'h4, instOf(4), HO);
    checkOutput("wrap.prime_count", {29'd0, o_count}, 32'd2);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 32'(8 + 4 * k), instOf(32'(8 + 4 * k)), RUN);
      checkAll($sformatf("wrap%0d", k), 1, 32'(4 * k), instOf(32'(4 * k)), 2, 1);
    end
    applyStimulus(0, 32'h0, 32'h0, FL);
    checkAll("wrap.flush", 0, 32'h0, NOP, 0, 1);

    // Asynchronous reset in the middle of a cycle with three entries queued.
    applyStimulus(1, 32'h0,  32'h0A0A0A0A, RUN);
    applyStimulus(1, 32'h50, instOf(32'h50), HO);
    applyStimulus(1, 32'h54, instOf(32'h54), HO);
    applyStimulus(1, 32'h58, instOf(32'h58), HO);
    checkOutput("pre_reset.count", {29'd0, o_count}, 32'd3);
    i_wr_valid = 1'b0;
    i_hold_flag = RUN;
    #1;
    i_reset = 1'b1;
    #1;
    checkOutput("midreset.count", {29'd0, o_count}, 32'd0);
    checkOutput("midreset.valid", {31'd0, o_valid}, 32'd0);
    checkOutput("midreset.inst",  o_inst_data, 32'h0);
    checkOutput("midreset.pc",    o_pc_addr, 32'h0);
    #2;
    i_reset = 1'b0;
    #1;
    checkOutput("postreset.ready", {31'd0, o_wr_ready}, 32'd1);
    applyStimulus(1, 32'h100, instOf(32'h100), RUN);
    checkAll("postreset.push", 1, 32'h100, instOf(32'h100), 0, 1);

`ifdef IF_ID_FIFO_PARITY_EN
    applyStimulus(0, 32'h0, 32'h0, FL);
    applyStimulus(1, 32'h40, instOf(32'h40), HO);
    applyStimulus(1, 32'h44, instOf(32'h44), HO);
    checkOutput("par.clean", {31'd0, o_parity_err}, 32'd0);
    dut.mem_par[0] = ~dut.mem_par[0];
    applyStimulus(0, 32'h0, 32'h0, RUN);
    checkOutput("par.load_pc", o_pc_addr, 32'h40);
    checkOutput("par.err_set", {31'd0, o_parity_err}, 32'd1);
    applyStimulus(0, 32'h0, 32'h0, RUN);
    checkOutput("par.sticky1", {31'd0, o_parity_err}, 32'd1);
    applyStimulus(0, 32'h0, 32'h0, RUN);
    checkOutput("par.sticky2", {31'd0, o_parity_err}, 32'd1);
    applyStimulus(0, 32'h0, 32'h0, FL);
    checkOutput("par.flush_clr", {31'd0, o_parity_err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/if_id_fifo.md
Name: if_id_fifo

Overview:
- Parametrised IF/ID decoupling buffer. It replaces the single-entry fetch/decode register with a DEPTH-entry instruction queue plus a registered output stage.
- Fetch pushes {pc, instruction} pairs with a valid/ready handshake. The ID stage reads the output stage.
- Hold and flush requests from EX use the existing `IF_ID_hold` / `IF_ID_flush` codes from defines.v.
- Lets fetch run ahead of decode during stalls.

Parameters:
- ADDR_W, 32, pc address width
- DATA_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, >= 2
- NOP_INST, 32'h00000013, instruction driven on flush/bubble

Ports:
- i_Clk  in  1  clock
- i_reset  in  1  asynchronous reset, active-high
- i_wr_valid  in  1  fetch presents a valid pc/instruction pair
- o_wr_ready  out  1  queue can accept a pair this cycle
- i_pc_addr  in  ADDR_W  pc of pushed instruction
- i_inst_data  in  DATA_W  pushed instruction
- i_hold_flag  in  2  EX control: `IF_ID_flush`, `IF_ID_hold`, other = run
- o_valid  out  1  output stage holds a real instruction
- o_pc_addr  out  ADDR_W  pc to ID
- o_inst_data  out  DATA_W  instruction to ID
- o_count  out  $clog2(DEPTH+1)  queue occupancy, excluding the output stage

Behaviour:
- Reset (async, mid-operation included) clears the queue:
  - o_count=0, o_valid=0, o_pc_addr=0, o_inst_data=0.
  - Write and read pointers = 0.
  - o_wr_ready=1 once reset deasserts.
- Storage: circular buffer, pointers of $clog2(DEPTH) bits, wrap modulo DEPTH, count tracked separately.
- o_wr_ready = (o_count != DEPTH). It is combinational from count only and never depends on i_wr_valid.
- Push = i_wr_valid & o_wr_ready.
- Priority per edge: flush > hold > run.
- Flush (i_hold_flag == `IF_ID_flush`):
  - Queue emptied: count=0, pointers=0.
  - Any same-cycle push is dropped.
  - Output stage <= {pc 0, NOP_INST}, o_valid=0.
- Hold (i_hold_flag == `IF_ID_hold`):
  - Output stage unchanged.
  - Push still accepted into the queue if not full.
- Run:
  - Output stage always reloads.
  - Queue non-empty: load head, pop, o_valid=1. A same-cycle push enqueues at the tail, so count stays unchanged.
  - Queue empty and push: bypass, input loads directly into the output stage with o_valid=1, and count stays 0. Latency is 1 cycle, matching the old single register.
  - Queue empty and no push: bubble, {0, NOP_INST}, o_valid=0.
- Full queue during run with a pop: o_wr_ready is still 0 that cycle. There is no same-cycle full-queue pass-through, so the queue can never overflow.
- Ordering is strictly FIFO. No instruction is dropped except by flush or reset.
- o_count is exact after every edge: +1 push only, -1 pop only, unchanged for both or neither.

Optional Feature:
- Macro IF_ID_FIFO_PARITY_EN.
- Enabled:
  - Each entry stores an extra even-parity bit over {pc, inst}, computed at push.
  - Parity is rechecked when the entry loads the output stage; bypass loads are always clean.
  - Mismatch sets extra output port o_parity_err (1 bit). It is sticky and cleared only by reset or flush.
- Disabled:
  - No parity storage and no o_parity_err port.
  - Timing and all other behaviour identical.

Test Plan:
- Reset mid-stream with 3 entries queued -> immediately o_count=0, o_valid=0, o_inst_data=0. After release, the first push of pc 0x100 appears on the next edge.
- Bypass: empty, run, push pc 0x0/inst 0x00500093 -> next edge o_valid=1, o_pc_addr=0x0, o_inst_data=0x00500093, o_count=0.
- Hold for 6 cycles with pushes every cycle, DEPTH=4:
  - Output frozen throughout.
  - o_count reaches 4, o_wr_ready=0 for the remaining cycles.
  - On release, pcs drain in push order 0x4, 0x8, 0xC, 0x10, with no loss or duplication.
- Flush with 3 queued plus a simultaneous push -> next edge o_count=0, o_valid=0, o_inst_data=0x00000013, o_pc_addr=0. The pushed pc never appears.
- Wrap: 10 push/pop cycles at steady count 2 -> pointers wrap. Output pcs strictly sequential 0x0..0x24, o_count stays 2.
- (PARITY_EN) Force a bit flip in a stored entry -> o_parity_err=1 when that entry loads, and it stays 1 until flush clears it.
